// File: rtl/game_pkg.sv
// Shared difficulty encodings for the HEX4 difficulty path.
package game_pkg;

  localparam int unsigned DIFF_W = 3;

  typedef logic [DIFF_W-1:0] diff_t;

  localparam diff_t DIFF_EASY  = 3'b001;
  localparam diff_t DIFF_MED   = 3'b010;
  localparam diff_t DIFF_HARD  = 3'b100;
  localparam diff_t DIFF_RESET = DIFF_EASY;

  // Highest pressed key wins; only meaningful when at least one press bit is set.
  function automatic diff_t diff_from_press(input logic [DIFF_W-1:0] press);
    if (press[2]) return DIFF_HARD;
    if (press[1]) return DIFF_MED;
    return DIFF_EASY;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Single pushbutton: two-flop synchroniser, stability counter and a
// one-cycle press pulse on the debounced released->pressed transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic key_n,
  output logic press
);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic             stable_q;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1    <= 1'b1;
      sync2    <= 1'b1;
      stable   <= 1'b1;
      stable_q <= 1'b1;
      cnt      <= '0;
    end else begin
      sync1    <= key_n;
      sync2    <= sync1;
      stable_q <= stable;
      // Any sample agreeing with the stable state restarts the stability window.
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable <= sync2;
        cnt    <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign press = ~stable & stable_q;

endmodule

// File: rtl/diff_select.sv
// Latched one-hot difficulty selection from KEY[3:1]; presses are only
// honoured while the game is idle (lock low).
module diff_select
  import game_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DIFF_W-1:0] key_n,
  input  logic              lock,
  output logic [DIFF_W-1:0] diff,
  output logic              diff_changed
);

  logic [DIFF_W-1:0] press;
  diff_t             diff_next;
  logic              take;

  key_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W          (CNT_W)
  ) u_key[DIFF_W-1:0] (
    .clk  (clk),
    .reset(reset),
    .key_n(key_n),
    .press(press)
  );

  always_comb begin
    diff_next = diff_from_press(press);
    take      = (|press) & ~lock;
  end

  // Press events arriving while locked are dropped, never queued.
  always_ff @(posedge clk) begin
    if (reset) begin
      diff         <= DIFF_RESET;
      diff_changed <= 1'b0;
    end else begin
      diff_changed <= 1'b0;
      if (take) begin
        diff         <= diff_next;
        diff_changed <= (diff_next != diff);
      end
    end
  end

  a_diff_onehot: assert property (@(posedge clk) disable iff (reset) $onehot(diff));

endmodule

// File: tb/tb_diff_select.sv
// Directed bench for diff_select with DEBOUNCE_CYCLES=4; every expected
// selection is queued with its due cycle and matched when diff moves.
module tb_diff_select;

  localparam int unsigned DC  = 4;
  localparam int          LAT = DC + 3;

  typedef struct {
    logic [2:0] diff;
    int         cyc;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] key_n;
  logic       lock;
  logic [2:0] diff;
  logic       diff_changed;

  int   cyc = 0;
  int   n_asserts = 0;
  int   n_fail = 0;
  exp_t q[$];
  logic [2:0] last_diff;

  diff_select #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk         (clk),
    .reset       (reset),
    .key_n       (key_n),
    .lock        (lock),
    .diff        (diff),
    .diff_changed(diff_changed)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_sel(input logic [2:0] d);
    q.push_back('{diff: d, cyc: cyc + LAT});
  endtask

  // Any movement of diff or any pulse must correspond to a queued expectation.
  always @(negedge clk) begin
    if (reset) begin
      last_diff = diff;
    end else if ((diff !== last_diff) || (diff_changed !== 1'b0)) begin
      check("event_expected", 32'(q.size() != 0), 32'd1);
      if (q.size() != 0) begin
        exp_t e;
        e = q.pop_front();
        check("diff_value", 32'(diff), 32'(e.diff));
        check("diff_cycle", cyc, e.cyc);
        check("pulse_with_change", 32'(diff_changed), 32'd1);
      end
      last_diff = diff;
    end
  end

  initial begin
    reset = 1'b1;
    key_n = 3'b111;
    lock  = 1'b0;

    // Reset and idle
    tick(2);
    check("reset_diff", 32'(diff), 32'h1);
    check("reset_pulse", 32'(diff_changed), 32'h0);
    reset = 1'b0;
    tick(20);
    check("idle_diff", 32'(diff), 32'h1);

    // Clean hard press
    key_n = 3'b011;
    expect_sel(3'b100);
    tick(10);
    key_n = 3'b111;
    tick(15);
    check("clean_hard", 32'(diff), 32'h4);

    // Bouncing medium key settles into one selection
    for (int unsigned i = 0; i < 4; i++) begin
      key_n = 3'b101;
      tick(3);
      key_n = 3'b111;
      tick(1);
    end
    check("bounce_hold", 32'(diff), 32'h4);
    key_n = 3'b101;
    expect_sel(3'b010);
    tick(10);
    key_n = 3'b111;
    tick(15);
    check("bounce_med", 32'(diff), 32'h2);

    // Lock discards the press; held key across unlock does nothing
    lock  = 1'b1;
    key_n = 3'b011;
    tick(10);
    check("locked_press", 32'(diff), 32'h2);
    lock = 1'b0;
    tick(10);
    check("held_after_unlock", 32'(diff), 32'h2);
    key_n = 3'b111;
    tick(10);
    key_n = 3'b011;
    expect_sel(3'b100);
    tick(10);
    key_n = 3'b111;
    tick(10);
    check("repress_after_unlock", 32'(diff), 32'h4);

    // Easy, then simultaneous press resolves to hard
    key_n = 3'b110;
    expect_sel(3'b001);
    tick(10);
    key_n = 3'b111;
    tick(10);
    key_n = 3'b000;
    expect_sel(3'b100);
    tick(10);
    key_n = 3'b111;
    tick(10);
    check("simultaneous", 32'(diff), 32'h4);

    // Re-pressing the current selection: no change, no pulse
    key_n = 3'b011;
    tick(10);
    key_n = 3'b111;
    tick(10);
    check("repress_same", 32'(diff), 32'h4);

    // Reset two cycles before debounce completes, key held throughout
    key_n = 3'b101;
    tick(2);
    reset = 1'b1;
    tick(2);
    check("midreset_diff", 32'(diff), 32'h1);
    check("midreset_pulse", 32'(diff_changed), 32'h0);
    reset = 1'b0;
    expect_sel(3'b010);
    tick(10);
    key_n = 3'b111;
    tick(10);
    check("after_midreset", 32'(diff), 32'h2);

    check("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
